// File: rtl/rr_arbiter_16_if.sv
// rr_arbiter_16_if: request/grant bundle between the 16 requesters and the
// round-robin arbiter.
//   req[15:0]       requester k asserts bit k
//   done            current owner has finished with the resource
//   grant[15:0]     one-hot grant (all zero when idle)
//   grant_idx[3:0]  binary index of the granted requester, 0 when idle
//   grant_valid     high while a grant is held
//   timeout         one-cycle pulse when a grant is revoked by the hold limit
interface rr_arbiter_16_if;
  logic [15:0] req;
  logic        done;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic        timeout;

  modport master (
    output req, done,
    input  grant, grant_idx, grant_valid, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_idx, grant_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16: 16-way round-robin arbiter with registered one-hot grant,
// binary grant index and an optional hold timeout.
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   bus      rr_arbiter_16_if.slave (req/done in, grant/grant_idx/
//            grant_valid/timeout out)
//
// state | meaning
// IDLE  | no grant held; rotating search of req from ptr
// BUSY  | grant held; waiting for done, withdrawal or hold limit
module rr_arbiter_16 #(
  parameter int unsigned MAX_HOLD = 256,
  parameter int unsigned CNT_W    = 16
) (
  input logic            clk,
  input logic            rst_n,
  rr_arbiter_16_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Terminal count of the hold counter; unused when MAX_HOLD is 0.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [3:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [15:0]        grant_q, grant_d;
  logic [3:0]         idx_q, idx_d;
  logic               timeout_q, timeout_d;

  logic               found;
  logic [3:0]         win_idx;
  logic               rel_done, rel_wd, rel_to, release_now;

  // Rotating-priority search: first set bit at or after ptr, wrapping 15->0.
  always_comb begin
    found   = 1'b0;
    win_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (!found && bus.req[4'(ptr_q + 4'(i))]) begin
        found   = 1'b1;
        win_idx = 4'(ptr_q + 4'(i));
      end
    end
  end

  always_comb begin
    rel_done    = bus.done;
    rel_wd      = ~bus.req[idx_q];
    rel_to      = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
    release_now = rel_done | rel_wd | rel_to;
  end

  // State register (outputs are registered alongside the state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 4'd0;
      hold_cnt_q <= '0;
      grant_q    <= 16'd0;
      idx_q      <= 4'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found)       state_d = BUSY;
      BUSY:    if (release_now) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d    = 16'd1 << win_idx;
          idx_d      = win_idx;
          hold_cnt_d = '0;
        end else begin
          grant_d = 16'd0;
          idx_d   = 4'd0;
        end
      end
      BUSY: begin
        if (release_now) begin
          grant_d   = 16'd0;
          idx_d     = 4'd0;
          ptr_d     = idx_q + 4'd1;
          // A timeout only counts when nothing else ended the grant.
          timeout_d = rel_to & ~rel_done & ~rel_wd;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        grant_d = 16'd0;
        idx_d   = 4'd0;
      end
    endcase
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = (state_q == BUSY);
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// tb_rr_arbiter_16: scoreboard bench for rr_arbiter_16 (MAX_HOLD = 4).
// A cycle-level reference model pushes the expected outputs for every clock
// edge; a monitor pops and compares them on the falling edge. Directed
// sequences add constant-valued checks on top.
module tb_rr_arbiter_16;
  localparam int MAXH = 4;

  logic clk;
  logic rst_n;
  rr_arbiter_16_if bus_if ();

  rr_arbiter_16 #(.MAX_HOLD(MAXH), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] grant;
    logic [3:0]  idx;
    logic        valid;
    logic        tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state: who owns the resource and for how many cycles.
  int owner = -1;
  int held  = 0;
  int ptr   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      owner = -1;
      held  = 0;
      ptr   = 0;
      exp_q.delete();
    end else begin
      e.grant = 16'd0;
      e.idx   = 4'd0;
      e.valid = 1'b0;
      e.tmo   = 1'b0;
      if (owner < 0) begin
        for (int i = 0; i < 16; i++) begin
          if (owner < 0 && bus_if.req[(ptr + i) % 16]) owner = (ptr + i) % 16;
        end
        if (owner >= 0) held = 1;
      end else begin
        bit by_done, by_wd, by_to;
        by_done = bus_if.done;
        by_wd   = !bus_if.req[owner];
        by_to   = (MAXH != 0) && (held == MAXH);
        if (by_done || by_wd || by_to) begin
          e.tmo = by_to && !by_done && !by_wd;
          ptr   = (owner + 1) % 16;
          owner = -1;
        end else begin
          held++;
        end
      end
      if (owner >= 0) begin
        e.grant = 16'(1) << owner;
        e.idx   = 4'(owner);
        e.valid = 1'b1;
      end
      exp_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_grant", 32'(bus_if.grant), 32'(e.grant));
      chk("sb_idx",   32'(bus_if.grant_idx), 32'(e.idx));
      chk("sb_valid", 32'(bus_if.grant_valid), 32'(e.valid));
      chk("sb_tmo",   32'(bus_if.timeout), 32'(e.tmo));
    end
  end

  task automatic do_reset();
    rst_n       = 1'b0;
    bus_if.req  = 16'd0;
    bus_if.done = 1'b0;
    @(negedge clk);
    chk("rst_grant", 32'(bus_if.grant), 32'd0);
    chk("rst_valid", 32'(bus_if.grant_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expect_out(input string name, input logic [15:0] g, input logic [3:0] idx,
                            input logic tmo);
    chk({name, "_grant"}, 32'(bus_if.grant), 32'(g));
    chk({name, "_idx"}, 32'(bus_if.grant_idx), 32'(idx));
    chk({name, "_valid"}, 32'(bus_if.grant_valid), 32'(g != 16'd0));
    chk({name, "_tmo"}, 32'(bus_if.timeout), 32'(tmo));
  endtask

  initial begin
    logic [15:0] r;
    do_reset();

    // Idle with no requests.
    repeat (10) begin
      @(negedge clk);
      expect_out("idle", 16'd0, 4'd0, 1'b0);
    end

    // Single requester 4, done ends it, then rotated search from ptr=5.
    bus_if.req = 16'h0010;
    @(negedge clk);
    expect_out("r4", 16'h0010, 4'd4, 1'b0);
    bus_if.done = 1'b1;
    @(negedge clk);
    bus_if.done = 1'b0;
    expect_out("r4_rel", 16'd0, 4'd0, 1'b0);
    bus_if.req = 16'h0009;
    @(negedge clk);
    expect_out("wrap0", 16'h0001, 4'd0, 1'b0);
    bus_if.done = 1'b1;
    @(negedge clk);
    bus_if.done = 1'b0;
    expect_out("wrap_rel", 16'd0, 4'd0, 1'b0);
    @(negedge clk);
    expect_out("next3", 16'h0008, 4'd3, 1'b0);
    bus_if.req = 16'd0;
    @(negedge clk);

    // Fairness: all requesting, done every cycle.
    do_reset();
    bus_if.req  = 16'hFFFF;
    bus_if.done = 1'b1;
    for (int g = 0; g < 17; g++) begin
      @(negedge clk);
      expect_out("rr", 16'(1) << (g % 16), 4'(g % 16), 1'b0);
      @(negedge clk);
      expect_out("rr_dead", 16'd0, 4'd0, 1'b0);
    end
    bus_if.done = 1'b0;
    bus_if.req  = 16'd0;

    // Hold timeout on requester 15, then regrant after the wrap.
    do_reset();
    bus_if.req = 16'h8000;
    for (int c = 0; c < MAXH; c++) begin
      @(negedge clk);
      expect_out("hold15", 16'h8000, 4'd15, 1'b0);
    end
    @(negedge clk);
    expect_out("tmo", 16'd0, 4'd0, 1'b1);
    @(negedge clk);
    expect_out("regrant15", 16'h8000, 4'd15, 1'b0);
    bus_if.req = 16'd0;
    @(negedge clk);

    // Async reset mid-grant.
    do_reset();
    bus_if.req = 16'h0080;
    @(negedge clk);
    expect_out("pre_rst7", 16'h0080, 4'd7, 1'b0);
    #2 rst_n = 1'b0;
    #1 expect_out("async_rst", 16'd0, 4'd0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    expect_out("post_rst7", 16'h0080, 4'd7, 1'b0);

    // Randomized traffic, checked by the scoreboard.
    r = 16'd0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       r = 16'hFFFF;
          1:       r = 16'(1) << $urandom_range(0, 15);
          2:       r = 16'($urandom);
          default: r = 16'($urandom) & 16'($urandom);
        endcase
      end
      bus_if.req  = r;
      bus_if.done = ($urandom_range(0, 4) == 0);
    end
    @(negedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
